vga_timing_gen: RTL and testbench

Generates the 640x480 @ 60 Hz VGA raster timing that drives the display pins and every pixel renderer in the Pong controller. It divides the board clock down to the pixel rate, runs the horizontal and vertical counters, and produces hsync/vsync. It also produces the `o_active`/`o_x`/`o_y` pixel-position stream and per-line/per-frame strobes that the ball and paddle renderers consume.

---
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 119 +++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters and registered sync,
// position and strobe outputs, all sharing one cycle of lag behind the counters.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk_in,
  input  logic       i_rst,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_active,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_pix_stb,
  output logic       o_line_end,
  output logic       o_frame_end
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       active;
    logic [9:0] x;
    logic [8:0] y;
    logic       pix_stb;
    logic       line_end;
    logic       frame_end;
  } vga_out_t;

  localparam vga_out_t OUT_RST = '{hs: 1'b1, vs: 1'b1, active: 1'b1, x: '0, y: '0,
                                   pix_stb: 1'b0, line_end: 1'b0, frame_end: 1'b0};

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt, v_cnt;
  logic             stb, h_wrap, v_wrap;
  logic [9:0]       y_full;
  vga_out_t         dec, out_q;

  assign stb    = (div_cnt == DIV_LAST);
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= stb ? '0 : div_cnt + 1'b1;
      if (stb) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end
    end
  end

  // Decode of the current counters; pulses use pre-advance values on the stb cycle.
  always_comb begin
    y_full        = (v_cnt < V_ACT) ? v_cnt : V_ACT - 10'd1;
    dec           = OUT_RST;
    dec.active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    dec.hs        = !((h_cnt >= H_SS) && (h_cnt < H_SE));
    dec.vs        = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    dec.x         = (h_cnt < H_ACT) ? h_cnt : H_ACT - 10'd1;
    dec.y         = y_full[8:0];
    dec.pix_stb   = stb;
    dec.line_end  = stb && h_wrap;
    dec.frame_end = stb && h_wrap && (v_cnt == V_ACT - 10'd1);
  end

  always_ff @(posedge clk_in) begin
    if (i_rst) out_q <= OUT_RST;
    else       out_q <= dec;
  end

  assign o_hs        = out_q.hs;
  assign o_vs        = out_q.vs;
  assign o_active    = out_q.active;
  assign o_x         = out_q.x;
  assign o_y         = out_q.y;
  assign o_pix_stb   = out_q.pix_stb;
  assign o_line_end  = out_q.line_end;
  assign o_frame_end = out_q.frame_end;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for line-level timing, plus two
// shrunken rasters (25x19 total, CLK_DIV 2 and 1) to cover whole frames quickly.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1, rst_s = 1'b1, rst_1 = 1'b1;

  logic       d_hs, d_vs, d_act, d_pix, d_line, d_frame;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       s_hs, s_vs, s_act, s_pix, s_line, s_frame;
  logic [9:0] s_x;
  logic [8:0] s_y;
  logic       u_hs, u_vs, u_act, u_pix, u_line, u_frame;
  logic [9:0] u_x;
  logic [8:0] u_y;

  vga_timing_gen u_def (
    .clk_in(clk), .i_rst(rst_d), .o_hs(d_hs), .o_vs(d_vs), .o_active(d_act),
    .o_x(d_x), .o_y(d_y), .o_pix_stb(d_pix), .o_line_end(d_line), .o_frame_end(d_frame));

  // Small raster: H 16/2/4/3 (total 25), V 12/2/2/3 (total 19).
  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                   .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_small (
    .clk_in(clk), .i_rst(rst_s), .o_hs(s_hs), .o_vs(s_vs), .o_active(s_act),
    .o_x(s_x), .o_y(s_y), .o_pix_stb(s_pix), .o_line_end(s_line), .o_frame_end(s_frame));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                   .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_one (
    .clk_in(clk), .i_rst(rst_1), .o_hs(u_hs), .o_vs(u_vs), .o_active(u_act),
    .o_x(u_x), .o_y(u_y), .o_pix_stb(u_pix), .o_line_end(u_line), .o_frame_end(u_frame));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Advance to just after release-relative rising edge e.
  task automatic go(input int e);
    while (cyc < e) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs", d_hs, 1);       chk("rst_vs", d_vs, 1);
    chk("rst_active", d_act, 1);  chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);         chk("rst_pix", d_pix, 0);
    chk("rst_line", d_line, 0);   chk("rst_frame", d_frame, 0);
    chk("rst_one_pix", u_pix, 0); chk("rst_small_hs", s_hs, 1);
    rst_d = 1'b0; rst_s = 1'b0; rst_1 = 1'b0;

    go(1);  chk("d_x_e1", d_x, 0); chk("d_pix_e1", d_pix, 0);
            chk("u_pix_e1", u_pix, 1); chk("u_x_e1", u_x, 0);
    go(2);  chk("d_x_e2", d_x, 0); chk("d_pix_e2", d_pix, 1);
    go(3);  chk("d_x_e3", d_x, 1); chk("d_pix_e3", d_pix, 0);
    go(4);  chk("d_x_e4", d_x, 1); chk("d_pix_e4", d_pix, 1);
    go(5);  chk("u_x_e5", u_x, 4); chk("u_pix_e5", u_pix, 1);
    go(20); chk("d_x_e20", d_x, 9);
    go(25); chk("u_line_e25", u_line, 1);
    go(49); chk("s_line_e49", s_line, 0);
    go(50); chk("s_line_e50", s_line, 1);
    go(51); chk("s_line_e51", s_line, 0); chk("s_y_e51", s_y, 1); chk("s_x_e51", s_x, 0);
    go(299); chk("u_frame_e299", u_frame, 0);
    go(300); chk("u_frame_e300", u_frame, 1); chk("u_pix_e300", u_pix, 1);
    go(599); chk("s_frame_e599", s_frame, 0);
    go(600); chk("s_frame_e600", s_frame, 1); chk("s_y_e600", s_y, 11);
    go(601); chk("s_frame_e601", s_frame, 0); chk("s_active_e601", s_act, 0);
             chk("s_y_e601", s_y, 11);
    go(651); chk("s_y_clamp_e651", s_y, 11);
    go(700); chk("s_vs_e700", s_vs, 1);
    go(701); chk("s_vs_e701", s_vs, 0);
    go(775); chk("u_frame_e775", u_frame, 1);
    go(800); chk("s_vs_e800", s_vs, 0);
    go(801); chk("s_vs_e801", s_vs, 1);
    go(950); chk("s_y_e950", s_y, 11);
    go(951); chk("s_y_wrap", s_y, 0); chk("s_x_wrap", s_x, 0); chk("s_active_wrap", s_act, 1);
    go(1250); chk("u_frame_e1250", u_frame, 1);
    go(1280); chk("d_active_e1280", d_act, 1); chk("d_x_e1280", d_x, 639);
    go(1281); chk("d_active_e1281", d_act, 0); chk("d_x_e1281", d_x, 639);
    go(1312); chk("d_hs_e1312", d_hs, 1);
    go(1313); chk("d_hs_e1313", d_hs, 0);
    go(1504); chk("d_hs_e1504", d_hs, 0);
    go(1505); chk("d_hs_e1505", d_hs, 1);
    go(1549); chk("s_frame_e1549", s_frame, 0);
    go(1550); chk("s_frame_e1550", s_frame, 1);
    go(1599); chk("d_line_e1599", d_line, 0); chk("d_x_e1599", d_x, 639);
    go(1600); chk("d_line_e1600", d_line, 1); chk("d_x_e1600", d_x, 639);
              chk("d_frame_e1600", d_frame, 0);
    go(1601); chk("d_line_e1601", d_line, 0); chk("d_x_e1601", d_x, 0); chk("d_y_e1601", d_y, 1);

    // Small raster sits at v=7, h=20 after edge 2290; pulse reset for one edge.
    go(2290); rst_s = 1'b1;
    go(2291); rst_s = 1'b0;
    chk("mid_rst_x", s_x, 0);   chk("mid_rst_y", s_y, 0);
    chk("mid_rst_hs", s_hs, 1); chk("mid_rst_vs", s_vs, 1);
    chk("mid_rst_pix", s_pix, 0);
    go(2292); chk("mid_rel_x", s_x, 0); chk("mid_rel_pix", s_pix, 0);
    go(2341); chk("mid_line", s_line, 1);
    go(2890); chk("mid_frame_early", s_frame, 0);
    go(2891); chk("mid_frame", s_frame, 1);
    go(3200); chk("d_line_e3200", d_line, 1); chk("d_y_e3200", d_y, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
